// File: rtl/fetch_ctrl.sv
// Purpose: program-counter / fetch sequencer driving the combinational instruction ROM address.
// Latency: a redirect (branch/jump/call/ret) sampled in cycle n is on prog_ctr in cycle n+1; no delay slot.
// Backpressure: stall holds prog_ctr and discards every lower-priority request in that cycle.
//
// Optional feature macro: FETCH_RSTACK_EN adds a STK_DEPTH-entry return-address stack
// (call_en/ret_en); without it call_en/ret_en are ignored and stack_err is 0.
//
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   start            - begins a run from IDLE or HALT (ignored while running)
//   stall, halt_req  - hold PC; accept halt instruction (hold PC, go HALT)
//   branch_taken/ofs - relative branch, signed offset from current PC
//   jump_en/target   - absolute jump
//   call_en, ret_en  - return-stack call/return (FETCH_RSTACK_EN only)
//   prog_ctr         - registered ROM address
//   running, done    - registered state flags (RUN, HALT)
//   stack_err        - sticky return-stack overflow/underflow flag

module fetch_ctrl #(
    parameter int D          = 10,
    parameter int START_ADDR = 0,
    parameter int OFS_W      = 8,
    parameter int STK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_taken,
    input  logic [OFS_W-1:0] branch_ofs,
    input  logic             jump_en,
    input  logic [D-1:0]     jump_target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [D-1:0]     prog_ctr,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    state_t       state;
    state_t       state_nxt;
    logic [D-1:0] pc_nxt;
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_br;
    logic [D-1:0] ofs_sext;

    // Size cast of a signed operand sign-extends (or truncates), so all PC
    // arithmetic naturally wraps modulo 2**D.
    assign ofs_sext = D'($signed(branch_ofs));
    assign pc_inc   = prog_ctr + D'(1);
    assign pc_br    = prog_ctr + ofs_sext;

`ifdef FETCH_RSTACK_EN
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [D-1:0]    stk [STK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_nxt;
    logic            push;
    logic            err_nxt;
    logic            stk_full;
    logic            stk_empty;
    logic [D-1:0]    stk_top;

    assign stk_full  = (sp == SP_W'(STK_DEPTH));
    assign stk_empty = (sp == '0);
    assign stk_top   = stk[IDX_W'(sp - SP_W'(1))];
`else
    logic unused_stack_inputs;
    localparam int unused_stk_depth = STK_DEPTH;
    assign unused_stack_inputs = call_en ^ ret_en;
    assign stack_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
`ifdef FETCH_RSTACK_EN
        sp_nxt    = sp;
        push      = 1'b0;
        err_nxt   = stack_err;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = START_PC;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = START_PC;
`ifdef FETCH_RSTACK_EN
                    sp_nxt    = '0;
                    err_nxt   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (stall) begin
                    pc_nxt = prog_ctr;
                end else if (halt_req) begin
                    // halt address stays on prog_ctr for the whole HALT period
                    state_nxt = S_HALT;
`ifdef FETCH_RSTACK_EN
                end else if (ret_en) begin
                    if (stk_empty) begin
                        pc_nxt  = pc_inc;
                        err_nxt = 1'b1;
                    end else begin
                        pc_nxt = stk_top;
                        sp_nxt = sp - SP_W'(1);
                    end
                end else if (call_en) begin
                    // the jump is taken even when the return address is lost
                    pc_nxt = jump_target;
                    if (stk_full) begin
                        err_nxt = 1'b1;
                    end else begin
                        push   = 1'b1;
                        sp_nxt = sp + SP_W'(1);
                    end
`endif
                end else if (jump_en) begin
                    pc_nxt = jump_target;
                end else if (branch_taken) begin
                    pc_nxt = pc_br;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            prog_ctr <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_ctr <= pc_nxt;
            running  <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_HALT);
        end
    end

`ifdef FETCH_RSTACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            stack_err <= err_nxt;
        end
    end

    // Entries need no reset: sp alone defines which ones are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stk[IDX_W'(sp)] <= pc_inc;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed test-plan steps followed by a randomized
// phase, every cycle checked against a queue-based behavioural model.

module tb_fetch_ctrl;

    localparam int D     = 10;
    localparam int OFS_W = 8;
    localparam int N     = 1 << D;
    localparam int DEPTH = 4;
    localparam int START = 0;
`ifdef FETCH_RSTACK_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stall;
    logic             halt_req;
    logic             branch_taken;
    logic [OFS_W-1:0] branch_ofs;
    logic             jump_en;
    logic [D-1:0]     jump_target;
    logic             call_en;
    logic             ret_en;
    logic [D-1:0]     prog_ctr;
    logic             running;
    logic             done;
    logic             stack_err;

    fetch_ctrl #(.D(D), .START_ADDR(START), .OFS_W(OFS_W), .STK_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .halt_req     (halt_req),
        .branch_taken (branch_taken),
        .branch_ofs   (branch_ofs),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .prog_ctr     (prog_ctr),
        .running      (running),
        .done         (done),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 = idle, 1 = run, 2 = halt
    int m_st;
    int m_pc;
    bit m_err;
    int m_stk[$];

    int vectors;
    int checks;
    int fails;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; stall = 0; halt_req = 0; branch_taken = 0;
        branch_ofs = '0; jump_en = 0; jump_target = '0; call_en = 0; ret_en = 0;
    endtask

    task automatic model_update();
        int ofs;
        ofs = int'($signed(branch_ofs));
        if (reset) begin
            m_st = 0; m_pc = 0; m_err = 0; m_stk.delete();
        end else if (m_st == 0) begin
            if (start) begin m_st = 1; m_pc = START; end
        end else if (m_st == 2) begin
            if (start) begin m_st = 1; m_pc = START; m_err = 0; m_stk.delete(); end
        end else begin
            if (stall) begin
                // hold everything
            end else if (halt_req) begin
                m_st = 2;
            end else if (RS && ret_en) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) % N; m_err = 1; end
            end else if (RS && call_en) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % N);
                else m_err = 1;
                m_pc = int'(jump_target);
            end else if (jump_en) begin
                m_pc = int'(jump_target);
            end else if (branch_taken) begin
                m_pc = (((m_pc + ofs) % N) + N) % N;
            end else begin
                m_pc = (m_pc + 1) % N;
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        vectors++;
        #1;
        chk("pc", 32'(prog_ctr), 32'(m_pc));
        chk("running", 32'(running), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_st == 2));
        chk("stack_err", 32'(stack_err), 32'(m_err));
    endtask

    task automatic jump_to(input int t);
        jump_en = 1; jump_target = D'(t);
        step();
        jump_en = 0;
    endtask

    initial begin
        vectors = 0; checks = 0; fails = 0;
        m_st = 0; m_pc = 0; m_err = 0;
        clear_inputs();

        // reset state
        reset = 1;
        step(); step();
        chk("reset_pc", 32'(prog_ctr), 0);
        chk("reset_running", 32'(running), 0);
        reset = 0;

        // IDLE ignores everything but start
        jump_en = 1; jump_target = 10'd77; branch_taken = 1;
        step();
        chk("idle_hold", 32'(prog_ctr), 0);
        clear_inputs();

        // start, then sequential fetch
        start = 1;
        step();
        start = 0;
        chk("start_pc", 32'(prog_ctr), 0);
        chk("start_running", 32'(running), 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("seq_pc", 32'(prog_ctr), 32'(i));
        end

        // relative branches
        branch_taken = 1; branch_ofs = 8'hFD;
        step();
        chk("branch_back", 32'(prog_ctr), 2);
        branch_ofs = 8'd100;
        step();
        chk("branch_fwd", 32'(prog_ctr), 102);
        branch_taken = 0;

        // stall drops a concurrent jump
        jump_to(7);
        stall = 1; jump_en = 1; jump_target = 10'd40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", 32'(prog_ctr), 7);
        end
        stall = 0; jump_en = 0;
        step();
        chk("stall_release", 32'(prog_ctr), 8);

        // wrap at top of address space
        jump_to(N - 1);
        step();
        chk("wrap_pc", 32'(prog_ctr), 0);
        jump_en = 1; jump_target = 10'd300; branch_taken = 1; branch_ofs = 8'd5;
        step();
        chk("jump_over_branch", 32'(prog_ctr), 300);
        clear_inputs();
        jump_to(2);
        branch_taken = 1; branch_ofs = 8'hFB;
        step();
        chk("neg_wrap", 32'(prog_ctr), N - 3);
        branch_taken = 0;

        // halt, HALT ignores controls, restart, start-in-RUN ignored
        jump_to(12);
        halt_req = 1;
        step();
        halt_req = 0;
        chk("halt_pc", 32'(prog_ctr), 12);
        chk("halt_done", 32'(done), 1);
        stall = 1; jump_en = 1; jump_target = 10'd99; branch_taken = 1; halt_req = 1;
        step(); step();
        chk("halt_hold", 32'(prog_ctr), 12);
        clear_inputs();
        start = 1;
        step();
        chk("restart_pc", 32'(prog_ctr), START);
        chk("restart_done", 32'(done), 0);
        step();
        chk("start_in_run", 32'(prog_ctr), 1);
        start = 0;
        step();
        reset = 1;
        step();
        chk("midrun_reset_pc", 32'(prog_ctr), 0);
        chk("midrun_reset_run", 32'(running), 0);
        reset = 0;

        start = 1; step(); start = 0;
        jump_to(10);
`ifdef FETCH_RSTACK_EN
        call_en = 1; jump_target = 10'd50;
        step();
        chk("call_pc", 32'(prog_ctr), 50);
        call_en = 0; ret_en = 1;
        step();
        chk("ret_pc", 32'(prog_ctr), 11);
        ret_en = 0;
        for (int i = 0; i < 5; i++) begin
            call_en = 1; jump_target = D'(100 + i);
            step();
            chk("nest_pc", 32'(prog_ctr), 32'(100 + i));
            chk("nest_err", 32'(stack_err), (i == 4) ? 1 : 0);
        end
        call_en = 0;
        stall = 1; ret_en = 1;
        step();
        chk("stall_no_pop", 32'(prog_ctr), 104);
        stall = 0;
        step();
        chk("pop_after_overflow", 32'(prog_ctr), 103);
        ret_en = 0;
        halt_req = 1; step(); halt_req = 0;
        start = 1; step(); start = 0;
        chk("err_cleared", 32'(stack_err), 0);
        ret_en = 1;
        step();
        chk("underflow_pc", 32'(prog_ctr), START + 1);
        chk("underflow_err", 32'(stack_err), 1);
        ret_en = 0;
`else
        call_en = 1; jump_target = 10'd50;
        step();
        chk("call_ignored", 32'(prog_ctr), 11);
        call_en = 0; ret_en = 1;
        step();
        chk("ret_ignored", 32'(prog_ctr), 12);
        chk("no_stack_err", 32'(stack_err), 0);
        ret_en = 0;
`endif

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 99) < 1);
            start        = ($urandom_range(0, 99) < 6);
            stall        = ($urandom_range(0, 99) < 15);
            halt_req     = ($urandom_range(0, 99) < 3);
            call_en      = ($urandom_range(0, 99) < 12);
            ret_en       = ($urandom_range(0, 99) < 12);
            jump_en      = ($urandom_range(0, 99) < 10);
            branch_taken = ($urandom_range(0, 99) < 25);
            branch_ofs   = OFS_W'($urandom());
            jump_target  = D'($urandom());
            step();
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
